// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per enabled clock,
// with a start/busy/done handshake and ena gating of all state.
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // state  | meaning
    // IDLE   | waiting for start; results held
    // RUN    | one restoring step per enabled edge, count down to 0
    // DONE   | results newly valid; done high for one enabled cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(DW);

    logic [1:0]    state_q;
    logic [DW-1:0] shift_q;
    logic [VW:0]   partial_q;
    logic [VW-1:0] divisor_q;
    logic [CW-1:0] count_q;

    logic [VW:0]   trial;
    logic [VW:0]   diff;
    logic          fits;
    logic [VW:0]   partial_nxt;
    logic [DW-1:0] shift_nxt;

    always_comb begin
        trial       = {partial_q[VW-1:0], shift_q[DW-1]};
        diff        = trial - {1'b0, divisor_q};
        fits        = (trial >= {1'b0, divisor_q});
        partial_nxt = fits ? diff : trial;
        shift_nxt   = {shift_q[DW-2:0], fits};
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            partial_q   <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_q   <= dividend;
                        divisor_q <= divisor;
                        partial_q <= '0;
                        count_q   <= CW'(DW - 1);
                        if (divisor == '0) begin
                            // No iterations needed; publish the saturated result now.
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    shift_q   <= shift_nxt;
                    partial_q <= partial_nxt;
                    if (count_q == '0) begin
                        // Final remainder is < divisor, so it fits in VW bits.
                        quotient    <= shift_nxt;
                        remainder   <= partial_nxt[VW-1:0];
                        div_by_zero <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random
// operands compared against plain integer division.
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done && ena && rst_n) done_cnt++;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply start for one edge, then count enabled edges until done shows.
    task automatic launch(input int a, input int b, output int lat);
        @(negedge clk);
        dividend = DW'(a);
        divisor  = VW'(b);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int exp_q, exp_r, exp_z;
        if (b == 0) begin
            exp_q = (1 << DW) - 1; exp_r = 0; exp_z = 1;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_z = 0;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, div_by_zero, exp_z);
    endtask

    task automatic full_op(input string tag, input int a, input int b);
        int lat;
        launch(a, b, lat);
        if (b == 0) check({tag, "_lat_dbz_le1"}, (lat <= 1), 1);
        else        check({tag, "_lat"}, lat, DW);
        check_result(tag, a, b);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        int lat, dc0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        full_op("d200_7", 200, 7);
        full_op("d225_15", 225, 15);
        full_op("d255_15", 255, 15);
        full_op("d35_5", 35, 5);
        full_op("d6_2", 6, 2);
        full_op("d10_0", 10, 0);
        full_op("d9_4", 9, 4);

        // Results hold between operations.
        repeat (4) @(negedge clk);
        check("hold_q", quotient, 2);
        check("hold_r", remainder, 1);

        // Start re-pulsed mid-RUN with other operands must be ignored.
        dc0 = done_cnt;
        @(negedge clk);
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dividend = 8'd100; divisor = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("midstart_q", quotient, 28);
        check("midstart_r", remainder, 4);
        check("midstart_ndone", done_cnt - dc0, 1);

        // ena low for 5 cycles mid-RUN stretches latency by 5.
        @(negedge clk);
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(negedge clk); lat++; end
        ena = 1'b0;
        repeat (5) begin @(negedge clk); lat++; end
        check("gate_busy", busy, 1);
        check("gate_done", done, 0);
        ena = 1'b1;
        while (!done && lat < 60) begin @(negedge clk); lat++; end
        check("gate_lat", lat, DW + 5);
        check_result("gate", 200, 7);
        // Hold done high while disabled in DONE.
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("gate_done_held", done, 1);
        ena = 1'b1;
        @(negedge clk);
        check("gate_done_release", done, 0);

        // Reset mid-RUN aborts with no done.
        dc0 = done_cnt;
        @(negedge clk);
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_ndone", done_cnt - dc0, 0);
        full_op("d0_9", 0, 9);

        // Random operands, divisor 0 included.
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range((1 << DW) - 1, 0));
            b = int'($urandom_range((1 << VW) - 1, 0));
            full_op("rand", a, b);
            if (b != 0)
                check("rand_invariant", int'(quotient) * b + int'(remainder), a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
